desalojo_ctrl: RTL and testbench
================================

DESALOJO_CTRL -- requirements
Module: desalojo_ctrl

Interface
REQ-001 Parameter: PTR_RESET, 0, reset value of the 2-bit clock-hand pointer (0..3).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset is asynchronous and active-high.
REQ-004 req  input  1  allocation request (miss), level, sampled only in IDLE.
REQ-005 hit  input  1  access hit this cycle.
REQ-006 hit_way  input  2  way index of hit.
REQ-007 wr  input  1  hit is a write (qualified by hit).
REQ-008 inv  input  1  invalidate request.
REQ-009 inv_way  input  2  way index to invalidate.
REQ-010 wb_ack  input  1  writeback complete, one-cycle pulse.
REQ-011 gnt  output  1  allocation granted, one-cycle pulse.
REQ-012 gnt_way  output  2  allocated way, valid while gnt=1.
REQ-013 wb_req  output  1  writeback request, held until wb_ack.
REQ-014 wb_way  output  2  victim way being written back, stable while wb_req=1.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 desalojo1  output  1  combinational: AND over ways of (valid[i] & ~ref[i]).
REQ-017 valid_o, ref_o, dirty_o  output  4 each  per-way state bits.

Function
REQ-018 Internal state: valid[3:0], ref[3:0], dirty[3:0], ptr[1:0], victim[1:0], FSM {IDLE, SCAN, WB, GRANT}.
REQ-019 IDLE, req=1, any valid[i]=0: victim = lowest i with valid[i]=0; next state GRANT (no scan, no writeback).
REQ-020 IDLE, req=1, all valid: next state SCAN.
REQ-021 SCAN, ref[ptr]=1: clear ref[ptr], ptr <= ptr+1 mod 4, stay SCAN.
REQ-022 SCAN, ref[ptr]=0: victim <= ptr; next WB if dirty[ptr]=1, else GRANT.
REQ-023 SCAN clear of ref[ptr] dominates a same-cycle hit on way ptr; scan length bounded to 5 cycles.
REQ-024 WB: wb_req=1, wb_way=victim; on wb_ack clear dirty[victim], next GRANT; wb_ack outside WB ignored.
REQ-025 GRANT: gnt=1, gnt_way=victim; at edge set valid[victim]=1, ref[victim]=1, dirty[victim]=0, ptr <= victim+1 mod 4; next IDLE.
REQ-026 gnt, wb_req decoded from state (Moore); gnt exactly one cycle per allocation.
REQ-027 hit in any state with valid[hit_way]=1: set ref[hit_way]; if wr, set dirty[hit_way]; hit on invalid way ignored.
REQ-028 hit to victim way during WB or GRANT ignored (way is being replaced).
REQ-029 inv accepted only in IDLE: clears valid, ref, dirty of inv_way; ignored when busy=1.
REQ-030 inv and req together in IDLE: inv applied first, allocation sees the freed way.
REQ-031 req ignored when busy=1; requester drops req in the gnt cycle; req still high in following IDLE starts a new allocation.
REQ-032 Latency: free way -> gnt 1 cycle after req sampled; full, clean, no ref set -> gnt 2 cycles after.

Reset
REQ-033 rst=1 asynchronously forces: FSM=IDLE, valid=ref=dirty=0, ptr=PTR_RESET, victim=0; gnt=wb_req=busy=0, gnt_way=wb_way=0, desalojo1=0.
REQ-034 rst mid-SCAN or mid-WB: wb_req drops immediately, pending allocation discarded, no gnt issued.

Verification
REQ-035 After reset, req four times back-to-back -> gnt_way 0,1,2,3, each gnt 1 cycle after req, valid_o=1111, ref_o=1111, desalojo1=0.
REQ-036 Full, ref=1111, ptr=0, req -> 4 clear cycles, victim 0, gnt_way=0 on 6th cycle after req, ref_o=0001 after grant, ptr=1.
REQ-037 Full, ref=0000, dirty=0100, ptr=2, req -> wb_req=1 wb_way=2 held 3 cycles until wb_ack, then gnt_way=2, dirty_o=0000.
REQ-038 Full, ref=0000 -> desalojo1=1; hit way 3 -> desalojo1=0, ref_o=1000; inv way 1 in IDLE -> valid_o=1101, next req grants way 1 without scan.
REQ-039 rst asserted while wb_req=1 -> wb_req=0 same cycle, all state bits 0, no gnt afterwards.
REQ-040 hit on ptr way in same cycle as SCAN clear -> ref bit ends 0, scan advances.

Source files
------------

// File: rtl/desalojo_ctrl.sv
// Clock-hand (second-chance) victim selector for a 4-way set: tracks per-way
// valid/ref/dirty bits, picks a victim on a miss, and handshakes a writeback when needed.
module desalojo_ctrl #(
    parameter logic [1:0] PTR_RESET = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       hit,
    input  logic [1:0] hit_way,
    input  logic       wr,
    input  logic       inv,
    input  logic [1:0] inv_way,
    input  logic       wb_ack,
    output logic       gnt,
    output logic [1:0] gnt_way,
    output logic       wb_req,
    output logic [1:0] wb_way,
    output logic       busy,
    output logic       desalojo1,
    output logic [3:0] valid_o,
    output logic [3:0] ref_o,
    output logic [3:0] dirty_o
);

    typedef enum logic [1:0] {IDLE, SCAN, WB, GRANT} state_t;

    state_t     state_q, state_d;
    logic [3:0] valid_q, valid_d;
    logic [3:0] ref_q, ref_d;
    logic [3:0] dirty_q, dirty_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] victim_q, victim_d;
    logic [2:0] scan_cnt_q, scan_cnt_d;

    logic [3:0] valid_post_inv;
    logic       free_found;
    logic [1:0] free_way;
    logic       hit_ok;
    logic [3:0] way_evictable;

    // Allocation in IDLE must see a way freed by a same-cycle invalidate.
    always_comb begin
        valid_post_inv = valid_q;
        if (inv) begin
            valid_post_inv[inv_way] = 1'b0;
        end
        free_found = 1'b0;
        free_way   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!valid_post_inv[i]) begin
                free_found = 1'b1;
                free_way   = 2'(i);
            end
        end
    end

    assign hit_ok = hit && valid_q[hit_way] &&
                    !(((state_q == WB) || (state_q == GRANT)) && (hit_way == victim_q));

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        ref_d      = ref_q;
        dirty_d    = dirty_q;
        ptr_d      = ptr_q;
        victim_d   = victim_q;
        scan_cnt_d = scan_cnt_q;

        if (hit_ok) begin
            ref_d[hit_way] = 1'b1;
            if (wr) begin
                dirty_d[hit_way] = 1'b1;
            end
        end

        // State-specific updates come after the hit so they win on the same way.
        case (state_q)
            IDLE: begin
                if (inv) begin
                    valid_d[inv_way] = 1'b0;
                    ref_d[inv_way]   = 1'b0;
                    dirty_d[inv_way] = 1'b0;
                end
                if (req) begin
                    if (free_found) begin
                        victim_d = free_way;
                        state_d  = GRANT;
                    end else begin
                        scan_cnt_d = 3'd0;
                        state_d    = SCAN;
                    end
                end
            end
            SCAN: begin
                // After four clears the hand is forced to take the way it points at.
                if (ref_q[ptr_q] && (scan_cnt_q != 3'd4)) begin
                    ref_d[ptr_q] = 1'b0;
                    ptr_d        = ptr_q + 2'd1;
                    scan_cnt_d   = scan_cnt_q + 3'd1;
                end else begin
                    victim_d = ptr_q;
                    state_d  = dirty_q[ptr_q] ? WB : GRANT;
                end
            end
            WB: begin
                if (wb_ack) begin
                    dirty_d[victim_q] = 1'b0;
                    state_d           = GRANT;
                end
            end
            GRANT: begin
                valid_d[victim_q] = 1'b1;
                ref_d[victim_q]   = 1'b1;
                dirty_d[victim_q] = 1'b0;
                ptr_d             = victim_q + 2'd1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= 4'd0;
            ref_q      <= 4'd0;
            dirty_q    <= 4'd0;
            ptr_q      <= PTR_RESET;
            victim_q   <= 2'd0;
            scan_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            ref_q      <= ref_d;
            dirty_q    <= dirty_d;
            ptr_q      <= ptr_d;
            victim_q   <= victim_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_evict
        assign way_evictable[gi] = valid_q[gi] & ~ref_q[gi];
    end

    assign desalojo1 = &way_evictable;
    assign gnt       = (state_q == GRANT);
    assign gnt_way   = gnt ? victim_q : 2'd0;
    assign wb_req    = (state_q == WB);
    assign wb_way    = wb_req ? victim_q : 2'd0;
    assign busy      = (state_q != IDLE);
    assign valid_o   = valid_q;
    assign ref_o     = ref_q;
    assign dirty_o   = dirty_q;

endmodule

// File: tb/tb_desalojo_ctrl.sv
// Bench for desalojo_ctrl: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the way bookkeeping.
module tb_desalojo_ctrl;

    localparam logic [1:0] TB_PTR_RESET = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0, hit = 1'b0, wr = 1'b0, inv = 1'b0, wb_ack = 1'b0;
    logic [1:0] hit_way = 2'd0, inv_way = 2'd0;
    logic       gnt, wb_req, busy, desalojo1;
    logic [1:0] gnt_way, wb_way;
    logic [3:0] valid_o, ref_o, dirty_o;

    int errors = 0;
    int checks = 0;

    desalojo_ctrl #(.PTR_RESET(TB_PTR_RESET)) dut (
        .clk(clk), .rst(rst), .req(req), .hit(hit), .hit_way(hit_way), .wr(wr),
        .inv(inv), .inv_way(inv_way), .wb_ack(wb_ack), .gnt(gnt), .gnt_way(gnt_way),
        .wb_req(wb_req), .wb_way(wb_way), .busy(busy), .desalojo1(desalojo1),
        .valid_o(valid_o), .ref_o(ref_o), .dirty_o(dirty_o)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_SCAN, M_WB, M_GRANT} phase_t;
    phase_t m_phase;
    bit     m_valid[4], m_ref[4], m_dirty[4];
    int     m_ptr, m_victim, m_clears;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] pack4(input bit a[4]);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = a[i];
        return r;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0; m_ref[i] = 0; m_dirty[i] = 0;
        end
        m_ptr = int'(TB_PTR_RESET); m_victim = 0; m_clears = 0;
    endtask

    task automatic model_step();
        bit nv[4], nr[4], nd[4];
        int first_free;
        nv = m_valid; nr = m_ref; nd = m_dirty;
        if (hit && m_valid[hit_way] &&
            !((m_phase == M_WB || m_phase == M_GRANT) && int'(hit_way) == m_victim)) begin
            nr[hit_way] = 1;
            if (wr) nd[hit_way] = 1;
        end
        case (m_phase)
            M_IDLE: begin
                if (inv) begin
                    nv[inv_way] = 0; nr[inv_way] = 0; nd[inv_way] = 0;
                end
                if (req) begin
                    first_free = -1;
                    for (int i = 3; i >= 0; i--) if (!nv[i]) first_free = i;
                    if (first_free >= 0) begin
                        m_victim = first_free; m_phase = M_GRANT;
                    end else begin
                        m_clears = 0; m_phase = M_SCAN;
                    end
                end
            end
            M_SCAN: begin
                if (m_ref[m_ptr] && m_clears < 4) begin
                    nr[m_ptr] = 0; m_ptr = (m_ptr + 1) % 4; m_clears++;
                end else begin
                    m_victim = m_ptr;
                    if (m_dirty[m_ptr]) m_phase = M_WB;
                    else m_phase = M_GRANT;
                end
            end
            M_WB: begin
                if (wb_ack) begin
                    nd[m_victim] = 0; m_phase = M_GRANT;
                end
            end
            M_GRANT: begin
                nv[m_victim] = 1; nr[m_victim] = 1; nd[m_victim] = 0;
                m_ptr = (m_victim + 1) % 4; m_phase = M_IDLE;
            end
        endcase
        m_valid = nv; m_ref = nr; m_dirty = nd;
    endtask

    task automatic compare_all();
        bit desal;
        desal = 1;
        for (int i = 0; i < 4; i++) desal = desal & m_valid[i] & !m_ref[i];
        check_eq("gnt", gnt, m_phase == M_GRANT);
        check_eq("gnt_way", gnt_way, (m_phase == M_GRANT) ? m_victim : 0);
        check_eq("wb_req", wb_req, m_phase == M_WB);
        check_eq("wb_way", wb_way, (m_phase == M_WB) ? m_victim : 0);
        check_eq("busy", busy, m_phase != M_IDLE);
        check_eq("desalojo1", desalojo1, desal);
        check_eq("valid_o", valid_o, pack4(m_valid));
        check_eq("ref_o", ref_o, pack4(m_ref));
        check_eq("dirty_o", dirty_o, pack4(m_dirty));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare mid-cycle.
    task automatic cycle(input logic r, input logic h, input logic [1:0] hw, input logic w,
                         input logic iv, input logic [1:0] iw, input logic ack);
        req = r; hit = h; hit_way = hw; wr = w; inv = iv; inv_way = iw; wb_ack = ack;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic hit_cycle(input logic [1:0] hw, input logic w);
        cycle(1'b0, 1'b1, hw, w, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        int n;
        int p;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check_eq("reset_busy", busy, 1'b0);
        rst = 1'b0;

        // Four back-to-back allocations fill ways 0..3 in order.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
            check_eq("fill_gnt", gnt, 1'b1);
            check_eq("fill_way", gnt_way, k);
            idle_cycle();
        end
        check_eq("fill_valid", valid_o, 4'hF);
        check_eq("fill_ref", ref_o, 4'hF);
        check_eq("fill_desalojo1", desalojo1, 1'b0);

        // All referenced, hand at 0: four clears then victim 0 on the 6th cycle.
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        n = 1;
        while (!gnt && n < 20) begin
            idle_cycle();
            n++;
        end
        check_eq("scan_latency", n, 6);
        check_eq("scan_gnt_way", gnt_way, 2'd0);
        idle_cycle();
        check_eq("scan_ref", ref_o, 4'b0001);

        // Dirty victim: writeback held three cycles until acknowledged.
        hit_cycle(2'd1, 1'b1);
        hit_cycle(2'd2, 1'b0);
        hit_cycle(2'd3, 1'b0);
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        n = 1;
        while (!wb_req && n < 20) begin
            idle_cycle();
            n++;
        end
        check_eq("wb_latency", n, 6);
        check_eq("wb_way", wb_way, 2'd1);
        idle_cycle();
        idle_cycle();
        check_eq("wb_held", wb_req, 1'b1);
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
        check_eq("wb_gnt_way", gnt_way, 2'd1);
        check_eq("wb_dirty", dirty_o, 4'b0000);
        idle_cycle();

        // Invalidate frees way 1, next request takes it without scanning.
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0);
        check_eq("inv_valid", valid_o, 4'b1101);
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        check_eq("inv_gnt", gnt, 1'b1);
        check_eq("inv_gnt_way", gnt_way, 2'd1);
        idle_cycle();

        // A hit on the hand's way during its clear leaves the bit clear.
        for (int w = 0; w < 4; w++) hit_cycle(2'(w), 1'b0);
        p = m_ptr;
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        hit_cycle(2'(p), 1'b0);
        check_eq("clear_beats_hit", ref_o[p], 1'b0);
        n = 0;
        while (!gnt && n < 20) begin
            idle_cycle();
            n++;
        end
        check_eq("clear_beats_hit_gnt", gnt, 1'b1);
        idle_cycle();

        // Asynchronous reset in the middle of a writeback.
        p = m_ptr;
        for (int w = 0; w < 4; w++) hit_cycle(2'(w), (w == p));
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        n = 0;
        while (!wb_req && n < 20) begin
            idle_cycle();
            n++;
        end
        check_eq("pre_rst_wb_req", wb_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_wb_req", wb_req, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_valid", valid_o, 4'd0);
        check_eq("rst_ref", ref_o, 4'd0);
        check_eq("rst_dirty", dirty_o, 4'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            check_eq("no_gnt_after_rst", gnt, 1'b0);
        end

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic r;
            r = ($urandom_range(0, 99) < 40) && (m_phase != M_GRANT);
            cycle(r, $urandom_range(0, 99) < 50, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
                  2'($urandom_range(0, 3)), $urandom_range(0, 99) < 30);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
